dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Sequences and shares the single-port 64-bit data memory between two requesters:
//  port 0 is the pipeline MEM stage (ld/sd family) and port 1 is the loader/debug master.
//  The block arbitrates, checks size/alignment/range, and forms byte strobes and lane-shifted
//  write data. On loads it extracts the addressed lane and sign- or zero-extends it.
// PARAMETERS
//  ADDR_W  12  byte-address width of the memory (size = 2**ADDR_W bytes, dword-organised)
//  RD_LAT  1   memory read latency in cycles, legal range 1..4
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-low (0 = reset)
//  rqN_req       in   1       N=0,1: access request; hold it and the fields below until rqN_gnt
//  rqN_we        in   1       1 = store, 0 = load
//  rqN_f3        in   3       RISC-V funct3: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU
//  rqN_addr      in   64      byte address (already computed rs1+imm)
//  rqN_wdata     in   64      store data, right-aligned
//  rqN_gnt       out  1       one-cycle pulse: request captured
//  rqN_rvalid    out  1       one-cycle pulse: access complete (also acknowledges stores)
//  rqN_rdata     out  64      extended load data; meaningful only with rvalid
//  rqN_err       out  1       address_error; meaningful only with rvalid
//  mem_en        out  1       memory access strobe
//  mem_we        out  1       memory write enable
//  mem_be        out  8       byte enables
//  mem_addr      out  ADDR_W-3  dword index
//  mem_wdata     out  64      lane-shifted write data
//  mem_rdata     in   64      read data, valid RD_LAT cycles after a read mem_en
// BEHAVIOUR
//  Reset: state IDLE; every output 0; RR pointer set so port 0 wins the first tie.
//   Reset is asynchronous and takes effect mid-access: mem_en drops at once and the
//   in-flight access is discarded with no rvalid.
//  FSM: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
//   IDLE: at the clock edge with any req, pick the winner and register its fields.
//   ISSUE (1 cycle): gnt=1 to the winner.
//    - Access legal: mem_en=1, mem_we=we.
//    - Access in error: mem_en=0.
//    - Next state: load -> WAIT; store or error -> RESP.
//   WAIT: counts RD_LAT cycles. mem_rdata is captured on the edge ending cycle ISSUE+RD_LAT.
//   RESP (1 cycle): rvalid=1 to the owner, with rdata and err. Next state is IDLE.
//  Latency: req sampled in cycle s.
//   - gnt in cycle s+1.
//   - Store/err rvalid in cycle s+2.
//   - Load rvalid in cycle s+2+RD_LAT.
//   - Back-to-back accesses are separated by one IDLE cycle.
//  Requester: drop req in the cycle after gnt. A req still high when the FSM returns to IDLE
//   is a new access.
//  Error conditions (err=1; no memory access; rdata is held):
//   - address misaligned to its size;
//   - rqN_addr >= 2**ADDR_W;
//   - f3=7;
//   - store with f3[2]=1.
//  Strobes: mem_be = ({1,2,4,8} ones) << addr[2:0]; mem_wdata = wdata << 8*addr[2:0].
//  Load extract: (mem_rdata >> 8*addr[2:0]) truncated to size; sign-extended for f3 0-2,
//   zero-extended for f3 3-6.
//  rdata/err hold their last value between rvalid pulses. Non-owner outputs stay 0.
// CONFIGURATION
//  DMEM_ARB_ROUND_ROBIN_EN defined:
//   - On a tie, the port not granted last wins.
//   - The pointer updates on every grant.
//  DMEM_ARB_ROUND_ROBIN_EN undefined:
//   - Fixed priority; port 0 always wins a tie.
//   - Port 1 can starve.
// TESTING
//  1. P0 SD addr 0x10 data 0xABCD123456789ABC:
//     mem_be=0xFF, mem_addr=2, rvalid at s+2.
//     Then LD 0x10 -> rdata 0xABCD123456789ABC at s+3, err=0.
//  2. P0 SB 0x80 @0x13:
//     mem_be=0x08, mem_wdata[31:24]=0x80.
//     LB @0x13 -> 0xFFFFFFFFFFFFFF80; LBU @0x13 -> 0x80.
//  3. LD @0x0F, and SW @0x1000 (ADDR_W=12):
//     err=1 at s+2, mem_en never high, rdata unchanged.
//  4. P0 and P1 request continuously, 4 accesses each.
//     Macro undefined: grants 0,0,0,0 then 1,1,1,1.
//     Macro defined: grants 0,1,0,1,0,1,0,1.
//  5. RD_LAT=3, LW @0x8 holding 0x00000000_F0000001 -> rdata 0xFFFFFFFFF0000001 at s+5.
//  6. reset=0 during WAIT of a load:
//     all outputs 0 immediately, no rvalid.
//     After release, P1 SD completes normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester port of dmem_arbiter (request fields, grant, response)
`timescale 1ns/1ps
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [2:0]  f3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;

  modport master (output req, we, f3, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, f3, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with lane alignment; DMEM_ARB_ROUND_ROBIN_EN selects round-robin ties
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     rq0,
  dmem_arbiter_if.slave     rq1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [7:0]        mem_be,
  output logic [ADDR_W-4:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;

  logic        own_q, we_q;
  logic [2:0]  f3_q;
  logic [63:0] addr_q, wdata_q;
  logic [1:0]  cnt_q;
  logic [63:0] rdata0_q, rdata1_q;
  logic        err0_q, err1_q;
  logic        any_req, win, capture;
  logic        misalign, acc_err, last_beat;
  logic [7:0]  be_base;
  logic [63:0] shifted, ext;
  logic        gnt, rvalid;

  assign any_req = rq0.req | rq1.req;
  assign capture = (state_q == IDLE) && any_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic prio_q;
  assign win = (rq0.req && rq1.req) ? prio_q : rq1.req;

  // tie-break pointer: after each grant the other port gets priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio_q <= 1'b0;
    else if (capture) prio_q <= ~win;
  end
`else
  assign win = ~rq0.req;
`endif

  assign acc_err   = misalign | (|addr_q[63:ADDR_W]) | (f3_q == 3'd7) | (we_q & f3_q[2]);
  assign shifted   = mem_rdata >> {addr_q[2:0], 3'b000};
  assign last_beat = (cnt_q == 2'(RD_LAT - 1));

  // access size decode: alignment mask and unshifted byte-enable pattern
  always_comb begin
    misalign = 1'b0;
    be_base  = 8'h01;
    case (f3_q[1:0])
      2'd0:    begin misalign = 1'b0;          be_base = 8'h01; end
      2'd1:    begin misalign = addr_q[0];     be_base = 8'h03; end
      2'd2:    begin misalign = |addr_q[1:0];  be_base = 8'h0F; end
      default: begin misalign = |addr_q[2:0];  be_base = 8'hFF; end
    endcase
  end

  // load lane extraction with sign/zero extension by funct3
  always_comb begin
    ext = shifted;
    case (f3_q)
      3'd0:    ext = {{56{shifted[7]}},  shifted[7:0]};
      3'd1:    ext = {{48{shifted[15]}}, shifted[15:0]};
      3'd2:    ext = {{32{shifted[31]}}, shifted[31:0]};
      3'd4:    ext = {56'd0, shifted[7:0]};
      3'd5:    ext = {48'd0, shifted[15:0]};
      3'd6:    ext = {32'd0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state and memory/handshake outputs
  always_comb begin
    state_d   = state_q;
    gnt       = 1'b0;
    rvalid    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: if (any_req) state_d = ISSUE;
      ISSUE: begin
        gnt = 1'b1;
        if (!acc_err) begin
          mem_en    = 1'b1;
          mem_we    = we_q;
          mem_be    = be_base << addr_q[2:0];
          mem_addr  = addr_q[ADDR_W-1:3];
          mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
        end
        state_d = (acc_err || we_q) ? RESP : WAIT;
      end
      WAIT: if (last_beat) state_d = RESP;
      default: begin
        rvalid  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // latch the winning requester's fields when leaving IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
    end else if (capture) begin
      own_q   <= win;
      we_q    <= win ? rq1.we    : rq0.we;
      f3_q    <= win ? rq1.f3    : rq0.f3;
      addr_q  <= win ? rq1.addr  : rq0.addr;
      wdata_q <= win ? rq1.wdata : rq0.wdata;
    end
  end

  // read latency counter, restarted at every issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt_q <= 2'd0;
    else if (state_q == ISSUE)  cnt_q <= 2'd0;
    else if (state_q == WAIT)   cnt_q <= cnt_q + 2'd1;
  end

  // per-port response registers; they hold between rvalid pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0_q <= 64'd0;
      rdata1_q <= 64'd0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        if (own_q) err1_q <= acc_err;
        else       err0_q <= acc_err;
      end
      if (state_q == WAIT && last_beat) begin
        if (own_q) rdata1_q <= ext;
        else       rdata0_q <= ext;
      end
    end
  end

  assign rq0.gnt    = gnt & ~own_q;
  assign rq1.gnt    = gnt & own_q;
  assign rq0.rvalid = rvalid & ~own_q;
  assign rq1.rvalid = rvalid & own_q;
  assign rq0.rdata  = rdata0_q;
  assign rq1.rdata  = rdata1_q;
  assign rq0.err    = err0_q;
  assign rq1.err    = err1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter (RD_LAT 1 and 3 instances)
`timescale 1ns/1ps
module tb_dmem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  dmem_arbiter_if a0 (), a1 (), b0 (), b1 ();

  logic        a_en, a_we, b_en, b_we;
  logic [7:0]  a_be, b_be;
  logic [8:0]  a_addr, b_addr;
  logic [63:0] a_wdata, a_rdata, b_wdata, b_rdata;

  dmem_arbiter #(.ADDR_W(12), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .rq0(a0), .rq1(a1),
    .mem_en(a_en), .mem_we(a_we), .mem_be(a_be), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata));

  dmem_arbiter #(.ADDR_W(12), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .rq0(b0), .rq1(b1),
    .mem_en(b_en), .mem_we(b_we), .mem_be(b_be), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata));

  // memory models: byte-enabled writes, RD_LAT-stage read pipelines
  logic [63:0] mem_a [512];
  logic [63:0] mem_b [512];
  logic [63:0] pa;
  logic [63:0] pb [3];
  always @(posedge clk) begin
    if (a_en) begin
      if (a_we) begin
        for (int i = 0; i < 8; i++) if (a_be[i]) mem_a[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end else pa <= mem_a[a_addr];
    end
    if (b_en) begin
      if (b_we) begin
        for (int i = 0; i < 8; i++) if (b_be[i]) mem_b[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
      end else pb[0] <= mem_b[b_addr];
    end
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign a_rdata = pa;
  assign b_rdata = pb[2];

  typedef struct {logic [63:0] rdata; logic err;} exp_t;
  exp_t sb0[$], sb1[$], sb2[$], sb3[$];
  logic [63:0] last_rd [2][2];
  int grant_log[$];
  int want_order[8];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic get_gnt(input int d, input int p);
    case ({d[0], p[0]})
      2'b00: return a0.gnt;
      2'b01: return a1.gnt;
      2'b10: return b0.gnt;
      default: return b1.gnt;
    endcase
  endfunction

  function automatic logic get_rvalid(input int d, input int p);
    case ({d[0], p[0]})
      2'b00: return a0.rvalid;
      2'b01: return a1.rvalid;
      2'b10: return b0.rvalid;
      default: return b1.rvalid;
    endcase
  endfunction

  function automatic exp_t get_resp(input int d, input int p);
    exp_t e;
    case ({d[0], p[0]})
      2'b00: begin e.rdata = a0.rdata; e.err = a0.err; end
      2'b01: begin e.rdata = a1.rdata; e.err = a1.err; end
      2'b10: begin e.rdata = b0.rdata; e.err = b0.err; end
      default: begin e.rdata = b1.rdata; e.err = b1.err; end
    endcase
    return e;
  endfunction

  function automatic int sb_size(input int d, input int p);
    case ({d[0], p[0]})
      2'b00: return sb0.size();
      2'b01: return sb1.size();
      2'b10: return sb2.size();
      default: return sb3.size();
    endcase
  endfunction

  task automatic sb_push(input int d, input int p, input exp_t e);
    case ({d[0], p[0]})
      2'b00: sb0.push_back(e);
      2'b01: sb1.push_back(e);
      2'b10: sb2.push_back(e);
      default: sb3.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int d, input int p, output exp_t e);
    case ({d[0], p[0]})
      2'b00: e = sb0.pop_front();
      2'b01: e = sb1.pop_front();
      2'b10: e = sb2.pop_front();
      default: e = sb3.pop_front();
    endcase
  endtask

  task automatic drive(input int d, input int p, input logic req, input logic we,
                       input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata);
    case ({d[0], p[0]})
      2'b00: begin a0.req = req; a0.we = we; a0.f3 = f3; a0.addr = addr; a0.wdata = wdata; end
      2'b01: begin a1.req = req; a1.we = we; a1.f3 = f3; a1.addr = addr; a1.wdata = wdata; end
      2'b10: begin b0.req = req; b0.we = we; b0.f3 = f3; b0.addr = addr; b0.wdata = wdata; end
      default: begin b1.req = req; b1.we = we; b1.f3 = f3; b1.addr = addr; b1.wdata = wdata; end
    endcase
  endtask

  task automatic mon(input int d, input int p);
    exp_t e, got;
    if (get_rvalid(d, p)) begin
      chk($sformatf("rvalid_expected d%0d p%0d", d, p), 64'(sb_size(d, p) != 0), 64'd1);
      if (sb_size(d, p) != 0) begin
        sb_pop(d, p, e);
        got = get_resp(d, p);
        chk($sformatf("rdata d%0d p%0d", d, p), got.rdata, e.rdata);
        chk($sformatf("err d%0d p%0d", d, p), 64'(got.err), 64'(e.err));
      end
    end
  endtask

  // response monitor and grant recorder, sampled mid-cycle
  always @(negedge clk) begin
    mon(0, 0); mon(0, 1); mon(1, 0); mon(1, 1);
    if (a0.gnt) grant_log.push_back(0);
    if (a1.gnt) grant_log.push_back(1);
  end

  task automatic acc(input int d, input int p, input logic we, input logic [2:0] f3,
                     input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] ld_val,
                     input logic want_err, input int want_lat, input logic [7:0] want_be,
                     input logic [63:0] want_wd, input string tag);
    exp_t e;
    int n;
    e.err   = want_err;
    e.rdata = (!we && !want_err) ? ld_val : last_rd[d][p];
    last_rd[d][p] = e.rdata;
    sb_push(d, p, e);
    drive(d, p, 1'b1, we, f3, addr, wdata);
    @(posedge clk); #1;
    chk({tag, " gnt"}, 64'(get_gnt(d, p)), 64'd1);
    if (d == 0) begin
      chk({tag, " mem_en"}, 64'(a_en), 64'(!want_err));
      if (!want_err) begin
        chk({tag, " mem_we"}, 64'(a_we), 64'(we));
        chk({tag, " mem_be"}, 64'(a_be), 64'(want_be));
        chk({tag, " mem_addr"}, 64'(a_addr), 64'(addr[11:3]));
        if (we) chk({tag, " mem_wdata"}, a_wdata, want_wd);
      end
    end
    drive(d, p, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    n = 1;
    while (!get_rvalid(d, p) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(want_lat));
    @(posedge clk); #1;
  endtask

  task automatic port_proc(input int p);
    exp_t e;
    int n;
    for (int k = 0; k < 4; k++) begin
      e.err = 1'b0;
      e.rdata = last_rd[0][p];
      sb_push(0, p, e);
      drive(0, p, 1'b1, 1'b1, 3'd3, 64'(32'h100 + p * 64 + k * 8), 64'(p * 16 + k));
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!get_gnt(0, p) && n < 100);
      chk($sformatf("t4 p%0d gnt %0d", p, k), 64'(get_gnt(0, p)), 64'd1);
    end
    drive(0, p, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    for (int i = 0; i < 512; i++) begin mem_a[i] = 64'd0; mem_b[i] = 64'd0; end
    mem_b[1] = 64'h00000000_F0000001;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        last_rd[d][p] = 64'd0;
        drive(d, p, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
      end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    want_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    want_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt", 64'(a0.gnt | a1.gnt), 64'd0);
    chk("reset rvalid", 64'(a0.rvalid | a1.rvalid), 64'd0);
    chk("reset rdata", a0.rdata, 64'd0);
    chk("reset err", 64'(a0.err), 64'd0);
    chk("reset mem_en", 64'(a_en), 64'd0);
    chk("reset mem_be", 64'(a_be), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    acc(0, 0, 1'b1, 3'd3, 64'h10, 64'hABCD123456789ABC, 64'd0, 1'b0, 2, 8'hFF, 64'hABCD123456789ABC, "t1 sd");
    acc(0, 0, 1'b0, 3'd3, 64'h10, 64'd0, 64'hABCD123456789ABC, 1'b0, 3, 8'hFF, 64'd0, "t1 ld");

    acc(0, 0, 1'b1, 3'd0, 64'h13, 64'h80, 64'd0, 1'b0, 2, 8'h08, 64'h80000000, "t2 sb");
    acc(0, 0, 1'b0, 3'd0, 64'h13, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0, 3, 8'h08, 64'd0, "t2 lb");
    acc(0, 0, 1'b0, 3'd4, 64'h13, 64'd0, 64'h80, 1'b0, 3, 8'h08, 64'd0, "t2 lbu");
    acc(0, 0, 1'b0, 3'd1, 64'h12, 64'd0, 64'hFFFFFFFFFFFF8078, 1'b0, 3, 8'h0C, 64'd0, "t2 lh");
    acc(0, 0, 1'b0, 3'd2, 64'h14, 64'd0, 64'hFFFFFFFFABCD1234, 1'b0, 3, 8'hF0, 64'd0, "t2 lw");
    acc(0, 0, 1'b0, 3'd5, 64'h16, 64'd0, 64'h000000000000ABCD, 1'b0, 3, 8'hC0, 64'd0, "t2 lhu");

    acc(0, 0, 1'b0, 3'd3, 64'h0F, 64'd0, 64'd0, 1'b1, 2, 8'h00, 64'd0, "t3 ld misaligned");
    acc(0, 0, 1'b1, 3'd2, 64'h1000, 64'h55, 64'd0, 1'b1, 2, 8'h00, 64'd0, "t3 sw range");
    acc(0, 0, 1'b0, 3'd7, 64'h18, 64'd0, 64'd0, 1'b1, 2, 8'h00, 64'd0, "t3 f3 7");
    acc(0, 0, 1'b1, 3'd4, 64'h18, 64'h11, 64'd0, 1'b1, 2, 8'h00, 64'd0, "t3 store unsigned");
    acc(0, 0, 1'b0, 3'd1, 64'h11, 64'd0, 64'd0, 1'b1, 2, 8'h00, 64'd0, "t3 lh misaligned");
    chk("t3 sd not written", mem_a[3], 64'd0);

    acc(1, 0, 1'b0, 3'd2, 64'h8, 64'd0, 64'hFFFFFFFFF0000001, 1'b0, 5, 8'h0F, 64'd0, "t5 lw lat3");

    grant_log.delete();
    fork
      port_proc(0);
      port_proc(1);
    join
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4 drained", 64'(sb0.size() + sb1.size()), 64'd0);
    chk("t4 grant count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) chk($sformatf("t4 grant %0d", i), 64'(grant_log[i]), 64'(want_order[i]));
    chk("t4 mem p1 last", mem_a[(32'h140 >> 3) + 3], 64'd19);
    @(posedge clk); #1;

    drive(0, 0, 1'b1, 1'b0, 3'd3, 64'h10, 64'd0);
    @(posedge clk); #1;
    chk("t6 gnt", 64'(a0.gnt), 64'd1);
    drive(0, 0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t6 mem_en", 64'(a_en), 64'd0);
    chk("t6 mem_be", 64'(a_be), 64'd0);
    chk("t6 mem_addr", 64'(a_addr), 64'd0);
    chk("t6 mem_wdata", a_wdata, 64'd0);
    chk("t6 rvalid", 64'(a0.rvalid | a1.rvalid), 64'd0);
    chk("t6 rdata", a0.rdata, 64'd0);
    chk("t6 err", 64'(a0.err), 64'd0);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) last_rd[d][p] = 64'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    acc(0, 1, 1'b1, 3'd3, 64'h20, 64'h0123456789ABCDEF, 64'd0, 1'b0, 2, 8'hFF, 64'h0123456789ABCDEF, "t6 p1 sd");
    acc(0, 1, 1'b0, 3'd3, 64'h20, 64'd0, 64'h0123456789ABCDEF, 1'b0, 3, 8'hFF, 64'd0, "t6 p1 ld");

    repeat (3) @(posedge clk);
    #1;
    chk("final scoreboard empty", 64'(sb0.size() + sb1.size() + sb2.size() + sb3.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
